// File: rtl/i2c_pkg.sv
// ============================================================================
// Package     : i2c_pkg
// Description : Shared definitions for the I2C master/target pair: the target
//               FSM state encoding and the R/W bit values of the address byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  // Target FSM state encoding (also exported on the debug state port).
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_state_e;

  // Value of the R/W bit (LSB of the address byte).
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage : i2c_pkg

`default_nettype wire

// File: rtl/i2c_line_sync.sv
// ============================================================================
// Module      : i2c_line_sync
// Description : Synchronises the asynchronous scl/sda lines into clk and
//               produces registered one-clk event pulses.
// Ports       : clk_i        system clock
//               rst_n_i      synchronous active-low reset
//               scl_i/sda_i  raw bus lines
//               scl_rise_o   scl rising edge seen
//               scl_fall_o   scl falling edge seen
//               start_det_o  sda fell while scl high
//               stop_det_o   sda rose while scl high
//               sda_o        synchronised sda, aligned with the pulses
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_rise_q, scl_fall_q, start_q, stop_q;
  logic w_scl, w_sda;

  assign w_scl = scl_sync_q[SYNC_STAGES-1];
  assign w_sda = sda_sync_q[SYNC_STAGES-1];

  // Chains reset to the idle-bus level (high) so leaving reset never
  // fabricates a START/STOP.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= w_scl;
      sda_prev_q <= w_sda;
      scl_rise_q <= w_scl & ~scl_prev_q;
      scl_fall_q <= ~w_scl & scl_prev_q;
      start_q    <= w_scl & scl_prev_q & sda_prev_q & ~w_sda;
      stop_q     <= w_scl & scl_prev_q & ~sda_prev_q & w_sda;
    end
  end

  assign scl_rise_o  = scl_rise_q;
  assign scl_fall_o  = scl_fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;
  // sda_prev_q holds the level sampled on the clk the pulses were computed.
  assign sda_o       = sda_prev_q;

endmodule : i2c_line_sync

`default_nettype wire

// File: rtl/i2c_slave_target.sv
// ============================================================================
// Module      : i2c_slave_target
// Description : Oversampled I2C target. Decodes START/STOP/address, accepts
//               write bytes, serialises read bytes and drives ACK.
// Ports       : clk, reset (sync, active-low), scl, sda_in  - clock/bus in
//               sda_oe              - 1 pulls sda low
//               rx_data/rx_valid    - received write byte and strobe
//               tx_data/tx_req      - read byte source and request strobe
//               addr_match, busy, state - status / debug
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addr_match,
  output logic       busy,
  output logic [2:0] state
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .scl_i       (scl),
    .sda_i       (sda_in),
    .scl_rise_o  (w_scl_rise),
    .scl_fall_o  (w_scl_fall),
    .start_det_o (w_start),
    .stop_det_o  (w_stop),
    .sda_o       (w_sda)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;
  logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d, tx_req_q, tx_req_d;
  logic       match_q, match_d, busy_q, busy_d, rw_q, rw_d;
  logic [7:0] w_shift_next;
  logic [2:0] w_bit_idx;

  // The 8th bit completes the byte directly from the line, so only 7 bits
  // ever need to be held.
  assign w_shift_next = {shift_q, w_sda};
  assign w_bit_idx    = 3'd7 - cnt_q[2:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    match_d    = match_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    // tx_data is taken on the clk where tx_req is high.
    tx_byte_d  = tx_req_q ? tx_data : tx_byte_q;

    if (w_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      match_d  = 1'b0;
      cnt_d    = 4'd0;
    end else if (w_start) begin
      state_d  = ADDR;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
      match_d  = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (w_scl_rise) begin
            shift_d = w_shift_next[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (w_shift_next[7:1] == SLAVE_ADDR) begin
                state_d = ADDR_ACK;
                match_d = 1'b1;
                rw_d    = w_shift_next[0];
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK, WR_ACK: begin
          // First falling edge starts the ACK, the second one ends it.
          if (w_scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
              if (state_q == ADDR_ACK && rw_q == RW_READ) tx_req_d = 1'b1;
            end else begin
              cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q == RW_READ) begin
                state_d  = RD_DATA;
                sda_oe_d = ~tx_byte_q[7];
              end else begin
                state_d  = WR_DATA;
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        WR_DATA: begin
          if (w_scl_rise) begin
            shift_d = w_shift_next[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rx_data_d  = w_shift_next;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        RD_DATA: begin
          // cnt_q = number of bits already sampled by the master.
          if (w_scl_rise && cnt_q != 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (w_scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d = ~tx_byte_q[w_bit_idx];
            end
          end
        end
        RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              // Cleared here so the next falling edge drives bit 7.
              tx_req_d = 1'b1;
              cnt_d    = 4'd0;
              state_d  = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
              match_d = 1'b0;
            end
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default:   state_d  = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 7'd0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      match_q    <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= RW_WRITE;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      match_q    <= match_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_req     = tx_req_q;
  assign addr_match = match_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule : i2c_slave_target

`default_nettype wire
